// File: rtl/fifo_sync_param_pkg.sv
// Shared defaults, mode constants and helpers for the parametrised sync FIFO.
// Imported by the interface, RAM and top level.
package fifo_sync_param_pkg;

    localparam int DEF_WIDTH = 128;
    localparam int DEF_DEPTH = 8;

    localparam bit FWFT_OFF = 1'b0;
    localparam bit FWFT_ON  = 1'b1;

    // Encoded as {wr_acc, rd_acc}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Write/read data path of the FIFO.
// Master drives requests; slave (the FIFO) returns read data.
interface fifo_sync_param_if
    import fifo_sync_param_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;

    modport master (
        output wr_en,
        output data_in,
        output rd_en,
        input  data_out,
        input  data_valid
    );

    modport slave (
        input  wr_en,
        input  data_in,
        input  rd_en,
        output data_out,
        output data_valid
    );

endinterface

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one async read port.
// Contents are deliberately not reset.
module fifo_ram
    import fifo_sync_param_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with thresholds, flush, sticky errors
// and selectable first-word-fall-through read.
module fifo_sync_param
    import fifo_sync_param_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter bit FWFT     = FWFT_OFF,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    fifo_sync_param_if.slave bus,
    output logic            empty,
    output logic            full,
    output logic            almost_empty,
    output logic            almost_full,
    output logic [AW:0]     count,
    output logic            overflow,
    output logic            underflow
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0]   AE_C    = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0]   ONE_C   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_INC = AW'(1);

    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_n;
    logic             empty_q;
    logic             full_q;
    logic             ae_q;
    logic             af_q;
    logic             ovf_q;
    logic             unf_q;
    logic             rd_acc;
    logic             wr_acc;
    logic [WIDTH-1:0] rdata;
    fifo_op_e         op;

    // Flush discards both requests, so it is folded into acceptance
    assign rd_acc = bus.rd_en & ~empty_q & ~flush;
    assign wr_acc = bus.wr_en & ~flush & (~full_q | rd_acc);
    assign op     = fifo_op_e'({wr_acc, rd_acc});

    always_comb begin
        cnt_n = cnt_q;
        unique case (op)
            OP_WR:   cnt_n = cnt_q + ONE_C;
            OP_RD:   cnt_n = cnt_q - ONE_C;
            OP_IDLE: cnt_n = cnt_q;
            OP_BOTH: cnt_n = cnt_q;
        endcase
        if (flush) begin
            cnt_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ae_q     <= 1'b1;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_INC;
                if (rd_acc) rd_ptr_q <= rd_ptr_q + PTR_INC;
            end
            cnt_q   <= cnt_n;
            empty_q <= (cnt_n == '0);
            full_q  <= (cnt_n == DEPTH_C);
            ae_q    <= (cnt_n <= AE_C);
            af_q    <= (cnt_n >= AF_C);
            if (flush) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end else begin
                if (bus.wr_en & ~wr_acc) ovf_q <= 1'b1;
                if (bus.rd_en & empty_q) unf_q <= 1'b1;
            end
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (bus.data_in),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    generate
        if (FWFT == FWFT_ON) begin : g_fwft
            // Head entry is presented directly; rd_en pops it
            assign bus.data_out   = rdata;
            assign bus.data_valid = ~empty_q;
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;
            logic             dv_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dout_q <= '0;
                    dv_q   <= 1'b0;
                end else begin
                    dv_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= rdata;
                    end
                end
            end

            assign bus.data_out   = dout_q;
            assign bus.data_valid = dv_q;
        end
    endgenerate

    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign count        = cnt_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench: one standard and one FWFT instance share stimulus
// and are checked each cycle against a queue-based reference model.
module tb_fifo_sync_param;

    localparam int W = 16;
    localparam int D = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         wr;
    logic         rd;
    logic         fl;
    logic [W-1:0] din;

    fifo_sync_param_if #(.WIDTH(W)) if_s ();
    fifo_sync_param_if #(.WIDTH(W)) if_f ();

    assign if_s.wr_en   = wr;
    assign if_s.rd_en   = rd;
    assign if_s.data_in = din;
    assign if_f.wr_en   = wr;
    assign if_f.rd_en   = rd;
    assign if_f.data_in = din;

    logic       e_s, f_s, ae_s, af_s, ov_s, un_s;
    logic       e_f, f_f, ae_f, af_f, ov_f, un_f;
    logic [3:0] c_s, c_f;

    fifo_sync_param #(
        .WIDTH(W), .DEPTH(D), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b0)
    ) u_std (
        .clk          (clk),
        .rst          (rst_n),
        .flush        (fl),
        .bus          (if_s),
        .empty        (e_s),
        .full         (f_s),
        .almost_empty (ae_s),
        .almost_full  (af_s),
        .count        (c_s),
        .overflow     (ov_s),
        .underflow    (un_s)
    );

    fifo_sync_param #(
        .WIDTH(W), .DEPTH(D), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b1)
    ) u_fwft (
        .clk          (clk),
        .rst          (rst_n),
        .flush        (fl),
        .bus          (if_f),
        .empty        (e_f),
        .full         (f_f),
        .almost_empty (ae_f),
        .almost_full  (af_f),
        .count        (c_f),
        .overflow     (ov_f),
        .underflow    (un_f)
    );

    int n_chk = 0;
    int n_bad = 0;

    int           m_cnt;
    bit           m_ovf;
    bit           m_unf;
    bit           m_dv;
    logic [W-1:0] m_dout;
    logic [W-1:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dv   = 1'b0;
        m_dout = '0;
        sb_q.delete();
    endtask

    task automatic check_all(input string t);
        chk({t, ".s.cnt"}, 32'(c_s), m_cnt);
        chk({t, ".s.empty"}, 32'(e_s), 32'(m_cnt == 0));
        chk({t, ".s.full"}, 32'(f_s), 32'(m_cnt == D));
        chk({t, ".s.ae"}, 32'(ae_s), 32'(m_cnt <= 2));
        chk({t, ".s.af"}, 32'(af_s), 32'(m_cnt >= 6));
        chk({t, ".s.ovf"}, 32'(ov_s), 32'(m_ovf));
        chk({t, ".s.unf"}, 32'(un_s), 32'(m_unf));
        chk({t, ".s.dv"}, 32'(if_s.data_valid), 32'(m_dv));
        chk({t, ".s.dout"}, 32'(if_s.data_out), 32'(m_dout));
        chk({t, ".f.cnt"}, 32'(c_f), m_cnt);
        chk({t, ".f.empty"}, 32'(e_f), 32'(m_cnt == 0));
        chk({t, ".f.full"}, 32'(f_f), 32'(m_cnt == D));
        chk({t, ".f.ae"}, 32'(ae_f), 32'(m_cnt <= 2));
        chk({t, ".f.af"}, 32'(af_f), 32'(m_cnt >= 6));
        chk({t, ".f.ovf"}, 32'(ov_f), 32'(m_ovf));
        chk({t, ".f.unf"}, 32'(un_f), 32'(m_unf));
        chk({t, ".f.dv"}, 32'(if_f.data_valid), 32'(m_cnt != 0));
        if (m_cnt != 0) begin
            chk({t, ".f.head"}, 32'(if_f.data_out), 32'(sb_q[0]));
        end
    endtask

    task automatic cycle(input bit w, input logic [W-1:0] d,
                         input bit r, input bit f, input string t);
        bit ra;
        bit wa;
        @(negedge clk);
        wr  = w;
        din = d;
        rd  = r;
        fl  = f;
        ra  = r && !f && (m_cnt != 0);
        wa  = w && !f && ((m_cnt != D) || ra);
        @(posedge clk);
        if (f) begin
            m_cnt = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_dv  = 1'b0;
            sb_q.delete();
        end else begin
            if (w && !wa) m_ovf = 1'b1;
            if (r && (m_cnt == 0)) m_unf = 1'b1;
            if (ra) m_dout = sb_q.pop_front();
            if (wa) sb_q.push_back(d);
            m_cnt = m_cnt + int'(wa) - int'(ra);
            m_dv  = ra;
        end
        #1;
        check_all(t);
    endtask

    task automatic async_reset(input string t);
        @(negedge clk);
        wr = 1'b1;
        rd = 1'b1;
        fl = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(t);
        wr = 1'b0;
        rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst_n = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        fl    = 1'b0;
        din   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("in_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("reset_idle");

        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, W'(i), 1'b0, 1'b0, $sformatf("fill%0d", i));
        end
        cycle(1'b1, 16'h0009, 1'b0, 1'b0, "fill_over");
        chk("over_flag", 32'(ov_s), 32'd1);
        chk("over_cnt", 32'(c_s), 32'd8);

        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, $sformatf("drain%0d", i));
            chk($sformatf("drain_data%0d", i), 32'(if_s.data_out), i);
        end
        cycle(1'b0, '0, 1'b1, 1'b0, "drain_under");
        chk("under_hold", 32'(if_s.data_out), 32'h8);
        chk("under_flag", 32'(un_s), 32'd1);

        cycle(1'b0, '0, 1'b0, 1'b1, "flush_a");
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, W'(16'h0010 + i), 1'b0, 1'b0, "fill_b");
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, W'(16'h0020 + i), 1'b1, 1'b0, "full_wr_rd");
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, "drain_b");
        end
        cycle(1'b1, 16'h0033, 1'b1, 1'b0, "empty_wr_rd");
        chk("ewr_cnt", 32'(c_s), 32'd1);
        chk("ewr_unf", 32'(un_s), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b1, "flush_b");

        for (int i = 0; i < 22; i++) begin
            cycle(i < 20, W'(16'h0100 + i), i >= 2, 1'b0, "wrap");
        end
        chk("wrap_last", 32'(if_s.data_out), 32'h0113);

        cycle(1'b1, 16'h000A, 1'b0, 1'b0, "fwft_wr");
        chk("fwft_data", 32'(if_f.data_out), 32'hA);
        chk("fwft_dv", 32'(if_f.data_valid), 32'd1);
        cycle(1'b0, '0, 1'b1, 1'b0, "fwft_pop");
        chk("fwft_empty", 32'(e_f), 32'd1);

        cycle(1'b0, '0, 1'b1, 1'b0, "pre_unf");
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, W'(16'h0040 + i), 1'b0, 1'b0, "fill_c");
        end
        cycle(1'b1, 16'h00EE, 1'b0, 1'b0, "pre_ovf");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, "to_five");
        end
        chk("five_cnt", 32'(c_s), 32'd5);
        cycle(1'b1, 16'h0077, 1'b0, 1'b1, "flush_wr");
        chk("flush_cnt", 32'(c_s), 32'd0);
        chk("flush_ovf", 32'(ov_s), 32'd0);
        chk("flush_unf", 32'(un_s), 32'd0);
        cycle(1'b1, 16'h0055, 1'b0, 1'b0, "post_flush_wr");
        cycle(1'b0, '0, 1'b1, 1'b0, "post_flush_rd");
        chk("post_flush_data", 32'(if_s.data_out), 32'h55);

        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, W'(16'h0060 + i), 1'b0, 1'b0, "burst");
        end
        cycle(1'b1, 16'h0063, 1'b1, 1'b0, "burst_rd");
        async_reset("async_rst");
        cycle(1'b1, 16'h0070, 1'b0, 1'b0, "after_rst_wr");
        cycle(1'b0, '0, 1'b1, 1'b0, "after_rst_rd");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
